// File: rtl/mas_pipe.sv
// Two-stage pipelined modular-arithmetic unit: ALU into s1, single modulus
// correction into s2, valid/ready on both sides, optional result chaining.
module mas_pipe #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   Sel,
    input  logic         chain,
    input  logic [W-1:0] Din1,
    input  logic [W-1:0] Din2,
    input  logic [W-1:0] Q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   TDout,
    output logic [1:0]   Tcmp,
    output logic [W-1:0] Dout
);

    typedef enum logic [1:0] {
        CMP_NONE = 2'b00,
        CMP_SUB  = 2'b01,
        CMP_ADD  = 2'b10
    } cmp_e;

    // Stage 1: ALU result and modulus of the most recently accepted transaction
    logic                r_s1_valid;
    logic signed [W:0]   r_s1_t;
    logic [W-1:0]        r_s1_q;

    // Stage 2: registered outputs
    logic                r_s2_valid;
    logic [W:0]          r_s2_tdout;
    cmp_e                r_s2_tcmp;
    logic [W-1:0]        r_s2_dout;

    logic [W-1:0]        r_acc;

    logic                w_in_fire;
    logic                w_s2_load;
    logic                w_s1_adv;
    logic [W-1:0]        w_a;
    logic signed [W:0]   w_a_ext;
    logic signed [W:0]   w_b_ext;
    logic signed [W:0]   w_alu;
    logic signed [W:0]   w_q_ext;
    logic [W-1:0]        w_r;
    cmp_e                w_cmp;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_fire = in_valid && in_ready;

    // A chained operand only fires while s1 advances, so forwarding C(s1) is safe
    assign w_a     = chain ? (r_s1_valid ? w_r : r_acc) : Din1;
    assign w_a_ext = {w_a[W-1], w_a};
    assign w_b_ext = {Din2[W-1], Din2};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_alu = w_a_ext;
        case (Sel)
            2'b00:   w_alu = w_a_ext + w_b_ext;
            2'b01:   w_alu = w_a_ext - w_b_ext;
            2'b10:   w_alu = w_b_ext - w_a_ext;
            default: w_alu = w_a_ext;
        endcase
    end

    // Compare at full W+1 precision; the low W bits of the sum are exact at W bits.
    assign w_q_ext = {r_s1_q[W-1], r_s1_q};

    always_comb begin
        w_cmp = CMP_NONE;
        w_r   = r_s1_t[W-1:0];
        if (r_s1_t >= w_q_ext) begin
            w_cmp = CMP_SUB;
            w_r   = r_s1_t[W-1:0] - r_s1_q;
        end else if (r_s1_t[W]) begin
            w_cmp = CMP_ADD;
            w_r   = r_s1_t[W-1:0] + r_s1_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_t     <= '0;
            r_s1_q     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_t     <= w_alu;
            r_s1_q     <= Q;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // NOTE: datapath registers are reset too because they drive ports
    // that must read zero during and after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_tdout <= '0;
            r_s2_tcmp  <= CMP_NONE;
            r_s2_dout  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= w_s1_adv;
            if (w_s1_adv) begin
                r_s2_tdout <= r_s1_t;
                r_s2_tcmp  <= w_cmp;
                r_s2_dout  <= w_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_s1_adv) begin
            r_acc <= w_r;
        end
    end

    assign out_valid = r_s2_valid;
    assign TDout     = r_s2_tdout;
    assign Tcmp      = r_s2_tcmp;
    assign Dout      = r_s2_dout;

endmodule

// File: tb/tb_mas_pipe.sv
// Scoreboard bench for mas_pipe: an integer reference model queues expected
// results at input acceptance and a negedge monitor checks them at output.
module tb_mas_pipe;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   Sel;
    logic         chain;
    logic [W-1:0] Din1;
    logic [W-1:0] Din2;
    logic [W-1:0] Q;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   TDout;
    logic [1:0]   Tcmp;
    logic [W-1:0] Dout;

    always #5 clk = ~clk;

    mas_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sel       (Sel),
        .chain     (chain),
        .Din1      (Din1),
        .Din2      (Din2),
        .Q         (Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .TDout     (TDout),
        .Tcmp      (Tcmp),
        .Dout      (Dout)
    );

    typedef struct {
        logic [W:0]   tdout;
        logic [1:0]   tcmp;
        logic [W-1:0] dout;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_assert = 0;
    int           n_fail   = 0;
    int           model_acc = 0;
    int           cyc = 0;
    logic [W-1:0] obs_dout[$];
    logic [1:0]   obs_tcmp[$];
    logic [W:0]   obs_tdout[$];
    int           obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx(input logic [W-1:0] v);
        logic signed [W-1:0] s;
        s = v;
        return int'(s);
    endfunction

    task automatic push_model(input int d1, input int d2, input int sel, input int ch, input int q);
        int   a, t, r, c;
        exp_t e;
        a = ch ? model_acc : d1;
        case (sel)
            0:       t = a + d2;
            1:       t = a - d2;
            2:       t = d2 - a;
            default: t = a;
        endcase
        if (t >= q)     begin r = t - q; c = 1; end
        else if (t < 0) begin r = t + q; c = 2; end
        else            begin r = t;     c = 0; end
        e.tdout = t[W:0];
        e.tcmp  = c[1:0];
        e.dout  = r[W-1:0];
        model_acc = sx(r[W-1:0]);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_dout.push_back(Dout);
            obs_tcmp.push_back(Tcmp);
            obs_tdout.push_back(TDout);
            obs_cyc.push_back(cyc);
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got TDout=%0d Tcmp=%b Dout=%0d, expected no output",
                         $signed(TDout), Tcmp, $signed(Dout));
            end else begin
                mon_e = sb.pop_front();
                if (TDout !== mon_e.tdout || Tcmp !== mon_e.tcmp || Dout !== mon_e.dout) begin
                    n_fail++;
                    $display("FAIL scoreboard: got TDout=%0d Tcmp=%b Dout=%0d, expected TDout=%0d Tcmp=%b Dout=%0d",
                             $signed(TDout), Tcmp, $signed(Dout),
                             $signed(mon_e.tdout), mon_e.tcmp, $signed(mon_e.dout));
                end
            end
        end
    end

    task automatic clear_obs();
        obs_dout.delete();
        obs_tcmp.delete();
        obs_tdout.delete();
        obs_cyc.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the transaction fires.
    task automatic send(input int d1, input int d2, input int sel, input int ch, input int q);
        int waited = 0;
        Din1 = d1[W-1:0];
        Din2 = d2[W-1:0];
        Sel  = sel[1:0];
        chain = ch[0];
        Q    = q[W-1:0];
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        n_assert++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end else begin
            push_model(d1, d2, sel, ch, q);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; Sel = 2'b00; chain = 1'b0;
        Din1 = '0; Din2 = '0; Q = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_assert++;
        if (TDout !== '0) begin n_fail++; $display("FAIL reset_tdout: got %0d, expected 0", TDout); end
        n_assert++;
        if (Tcmp !== 2'b00) begin n_fail++; $display("FAIL reset_tcmp: got %b, expected 00", Tcmp); end
        n_assert++;
        if (Dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0d, expected 0", Dout); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_add_wrap();
        clear_obs();
        Din1 = 5'd5; Din2 = 5'd4; Sel = 2'b00; chain = 1'b0; Q = 5'd7;
        in_valid = 1'b1;
        @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b, expected 1", in_ready); end
        push_model(5, 4, 0, 0, 7);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: out_valid=%b one cycle after accept, expected 0", out_valid); end
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid=%b two cycles after accept, expected 1", out_valid); end
        drain();
        n_assert++;
        if (obs_dout.size() != 1 || obs_tdout[0] !== 6'd9 || obs_tcmp[0] !== 2'b01 || obs_dout[0] !== 5'd2) begin
            n_fail++;
            $display("FAIL add_wrap: got %0d results, first TDout=%0d Tcmp=%b Dout=%0d, expected 1 result 9/01/2",
                     obs_dout.size(), obs_tdout[0], obs_tcmp[0], obs_dout[0]);
        end
    endtask

    task automatic test_sub();
        clear_obs();
        send(2, 6, 1, 0, 7);
        send(6, 2, 2, 0, 7);
        drain();
        for (int i = 0; i < 2; i++) begin
            n_assert++;
            if (obs_dout.size() != 2 || obs_tdout[i] !== 6'b111100 || obs_tcmp[i] !== 2'b10 || obs_dout[i] !== 5'd3) begin
                n_fail++;
                $display("FAIL sub_%0d: got TDout=%0d Tcmp=%b Dout=%0d, expected -4/10/3",
                         i, $signed(obs_tdout[i]), obs_tcmp[i], obs_dout[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d[3];
        logic [1:0]   exp_c[3];
        exp_d[0] = 5'd5; exp_d[1] = 5'd4; exp_d[2] = 5'd3;
        exp_c[0] = 2'b01; exp_c[1] = 2'b01; exp_c[2] = 2'b00;
        clear_obs();
        send(6, 6, 0, 0, 7);
        send(9, 6, 0, 1, 7);
        send(-11, 1, 1, 1, 7);
        drain();
        n_assert++;
        if (obs_dout.size() != 3) begin
            n_fail++;
            $display("FAIL chain_count: got %0d results, expected 3", obs_dout.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (obs_dout[i] !== exp_d[i] || obs_tcmp[i] !== exp_c[i]) begin
                    n_fail++;
                    $display("FAIL chain_%0d: got Dout=%0d Tcmp=%b, expected Dout=%0d Tcmp=%b",
                             i, obs_dout[i], obs_tcmp[i], exp_d[i], exp_c[i]);
                end
            end
            n_assert++;
            if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
                n_fail++;
                $display("FAIL chain_throughput: output cycles %0d %0d %0d, expected consecutive",
                         obs_cyc[0], obs_cyc[1], obs_cyc[2]);
            end
        end
    endtask

    task automatic test_extremes();
        clear_obs();
        send(15, 15, 0, 0, 15);
        send(-16, 15, 1, 0, 15);
        drain();
        n_assert++;
        if (obs_dout.size() != 2 || obs_tdout[0] !== 6'd30 || obs_tcmp[0] !== 2'b01 || obs_dout[0] !== 5'd15) begin
            n_fail++;
            $display("FAIL extreme_add: got TDout=%0d Tcmp=%b Dout=%0d, expected 30/01/15",
                     $signed(obs_tdout[0]), obs_tcmp[0], $signed(obs_dout[0]));
        end
        n_assert++;
        if (obs_dout.size() != 2 || obs_tdout[1] !== 6'b100001 || obs_tcmp[1] !== 2'b10 || obs_dout[1] !== 5'b10000) begin
            n_fail++;
            $display("FAIL extreme_sub: got TDout=%0d Tcmp=%b Dout=%0d, expected -31/10/-16",
                     $signed(obs_tdout[1]), obs_tcmp[1], $signed(obs_dout[1]));
        end
    endtask

    task automatic test_backpressure();
        clear_obs();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                         int'($urandom_range(3)), int'($urandom_range(1)),
                         int'($urandom_range(15, 1)));
                end
            end
            begin
                logic [W:0]   h_t;
                logic [1:0]   h_c;
                logic [W-1:0] h_d;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                h_t = TDout; h_c = Tcmp; h_d = Dout;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        n_assert++;
                        if (out_valid !== 1'b1 || TDout !== h_t || Tcmp !== h_c || Dout !== h_d) begin
                            n_fail++;
                            $display("FAIL bp_hold_%0d: got v=%b %0d/%b/%0d, expected v=1 %0d/%b/%0d",
                                     i, out_valid, TDout, Tcmp, Dout, h_t, h_c, h_d);
                        end
                    end
                    n_assert++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bp_in_ready_%0d: got %b while both stages full, expected 0", i, in_ready);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        n_assert++;
        if (obs_dout.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, expected 6", obs_dout.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(3, 2, 0, 0, 7);
        send(1, 1, 0, 0, 7);
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_full: got out_valid=%b in_ready=%b, expected 1/0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || TDout !== '0 || Tcmp !== 2'b00 || Dout !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got v=%b %0d/%b/%0d, expected all 0", out_valid, TDout, Tcmp, Dout);
        end
        sb.delete();
        model_acc = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        clear_obs();
        send(9, 3, 0, 1, 7);
        drain();
        n_assert++;
        if (obs_dout.size() != 1 || obs_dout[0] !== 5'd3) begin
            n_fail++;
            $display("FAIL rstmid_chain: got %0d results, Dout=%0d, expected 1 result Dout=3",
                     obs_dout.size(), obs_dout[0]);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_back_to_back();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mas_pipe.md
# mas_pipe

Parametrised, pipelined successor to the two-input modular-arithmetic stage. Each accepted transaction is computed in two steps: an ALU operation on two signed operands, then a single modulus correction against a per-transaction modulus Q. Results stream out with a valid/ready handshake. A chain mode feeds each result back as the first operand of the next transaction, so N-operand modular expressions run at full throughput.

## Interface
- W, 5: operand, modulus and result width in bits, two's-complement; legal range 3..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  transaction offered.
- in_ready  out  1  transaction can be accepted this cycle.
- Sel  in  2  ALU op: 00 Din1+Din2, 01 Din1-Din2, 10 Din2-Din1, 11 pass Din1.
- chain  in  1  1 = replace Din1 with the previous transaction's corrected result.
- Din1  in  W  signed operand 1; ignored when chain=1.
- Din2  in  W  signed operand 2.
- Q  in  W  signed modulus, sampled with the transaction.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- TDout  out  W+1  signed ALU result before correction.
- Tcmp  out  2  correction applied: 00 none, 01 Q subtracted, 10 Q added.
- Dout  out  W  low W bits of the corrected result.

## Operation
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Stage 1 register s1 holds the following, loaded on in_fire:
  - T = ALU(A, Din2, Sel), computed at W+1 bits with sign extension, so it never overflows.
  - Q, sign-extended.
  - A = Din1 when chain=0; the chain operand when chain=1.
- Correction C(s1), combinational, evaluated in this priority order:
  - T >= Q: R = T-Q, Tcmp=01.
  - else T < 0: R = T+Q, Tcmp=10.
  - else R = T, Tcmp=00.
  - R is computed at W+2 bits; Dout = R[W-1:0], i.e. truncated, no saturation.
  - Only a single correction is applied, so the result can still lie outside [0,Q-1] when operands are out of range; this is intended.
- Stage 2 register s2 holds TDout, Tcmp and Dout, loaded from s1 when s1 advances.
- Pipeline control:
  - s2 can load when it is empty or out_fire.
  - s1 advances when it is valid and s2 can load.
  - in_ready = !s1_valid | s1_advance; it is independent of input data.
- Chain operand:
  - If s1 is valid, use C(s1).R[W-1:0] by combinational forwarding. s1 always holds the most recently accepted transaction, and the forward is only used when s1_advance, because in_ready guarantees this.
  - Otherwise use acc_r.
  - acc_r is loaded with C(s1).R[W-1:0] every time s1 advances.
- chain=1 with no prior transaction since reset: operand is acc_r = 0.
- Q <= 0 is legal and produces defined arithmetic; no error flag.

## Timing
- Latency: in_fire at edge k gives out_valid high after edge k+1 (two-register pipe), provided out_ready was held.
- Throughput: one transaction per cycle, including back-to-back chain=1 transactions.
- Backpressure:
  - out_valid=1 with out_ready=0 holds TDout, Tcmp and Dout stable.
  - s1 then fills, and in_ready drops in the cycle after s1 holds data and s2 is stalled.
  - No transaction is lost or duplicated.
- Simultaneous out_fire, s1 advance and in_fire in one cycle: all three occur; the pipe stays full.
- Reset (asynchronous, any time, including mid-stream):
  - s1_valid=0, s2_valid=0, acc_r=0.
  - out_valid=0, TDout=0, Tcmp=00, Dout=0.
  - in_ready=1 from the first edge after deassertion.
  - In-flight transactions are discarded.
- Outputs are registered; only in_ready is combinational (from pipe state and out_ready).

## Test plan
- Add with wrap, W=5, Q=7: Din1=5, Din2=4, Sel=00, chain=0 → TDout=9, Tcmp=01, Dout=2; 2-cycle latency.
- Sub with correction, Q=7: Din1=2, Din2=6, Sel=01 → TDout=-4, Tcmp=10, Dout=3. Reverse-sub Din1=6, Din2=2, Sel=10 → same result.
- Back-to-back chain, Q=7, sent on consecutive cycles:
  - (Din1=6, Din2=6, Sel=00, chain=0)
  - (Din2=6, Sel=00, chain=1)
  - (Din2=1, Sel=01, chain=1)
  - Required: Dout 5, 4, 3 on consecutive cycles with Tcmp 01, 01, 00.
- Width extremes, W=5, Q=15:
  - Din1=15, Din2=15, Sel=00 → TDout=30, Tcmp=01, Dout=15.
  - Din1=-16, Din2=15, Sel=01 → TDout=-31, Tcmp=10, Dout=-16.
- Backpressure: 6 random transactions with out_ready low for 3 cycles mid-stream → outputs held stable, in_ready low while both stages are full, all 6 results delivered in order and matching the model.
- Reset mid-stream: assert rst with both stages full → out_valid=0 and all outputs 0 immediately. After deassertion, a chain=1, Din2=3, Sel=00, Q=7 transaction yields Dout=3 (acc_r cleared).
